// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for instruction fetch, load/store and debug requesters.
// One transaction in flight: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (latency) -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  input  logic [3:0]            ls_req_wstrb,
  output logic                  ls_rsp_valid,

  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic                  dbg_req_we,
  input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
  input  logic [3:0]            dbg_req_wstrb,
  output logic                  dbg_rsp_valid,

  output logic [DATA_WIDTH-1:0] rsp_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy
);

  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {G_IF, G_LS, G_DBG} gnt_t;

  typedef struct packed {
    logic                  we;
    logic [WA_W-1:0]       addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
  } req_t;

  state_t                state_q, state_d;
  gnt_t                  gnt_q, gnt_d;
  gnt_t                  rr_last_q, rr_last_d;
  req_t                  req_q, req_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic win_vld;
  gnt_t win;
  req_t req_sel;

  // Byte-offset bits are intentionally discarded: accesses are word-aligned.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_req_addr[1:0], ls_req_addr[1:0], dbg_req_addr[1:0]};

  // Arbitration: dbg absolute, if/ls round-robin against the last if/ls grant.
  always_comb begin
    win_vld = 1'b0;
    win     = G_IF;
    if (state_q == IDLE && !reset) begin
      if (dbg_req_valid) begin
        win_vld = 1'b1;
        win     = G_DBG;
      end else if (if_req_valid && ls_req_valid) begin
        win_vld = 1'b1;
        win     = (rr_last_q == G_LS) ? G_IF : G_LS;
      end else if (if_req_valid) begin
        win_vld = 1'b1;
        win     = G_IF;
      end else if (ls_req_valid) begin
        win_vld = 1'b1;
        win     = G_LS;
      end
    end
  end

  assign if_req_ready  = win_vld && (win == G_IF);
  assign ls_req_ready  = win_vld && (win == G_LS);
  assign dbg_req_ready = win_vld && (win == G_DBG);

  always_comb begin
    req_sel = '0;
    case (win)
      G_DBG: begin
        req_sel.we    = dbg_req_we;
        req_sel.addr  = dbg_req_addr[ADDR_WIDTH-1:2];
        req_sel.wdata = dbg_req_wdata;
        req_sel.wstrb = dbg_req_wstrb;
      end
      G_LS: begin
        req_sel.we    = ls_req_we;
        req_sel.addr  = ls_req_addr[ADDR_WIDTH-1:2];
        req_sel.wdata = ls_req_wdata;
        req_sel.wstrb = ls_req_wstrb;
      end
      default: begin
        req_sel.addr  = if_req_addr[ADDR_WIDTH-1:2];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ISSUE;
          gnt_d   = win;
          req_d   = req_sel;
          if (win != G_DBG) rr_last_d = win;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Last WAIT cycle is exactly MEM_LATENCY cycles after mem_en.
        if (cnt_q == 1) begin
          rdata_d = req_q.we ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= G_IF;
      rr_last_q <= G_LS;
      req_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & req_q.we;
  assign mem_addr  = mem_en ? req_q.addr  : '0;
  assign mem_wdata = mem_en ? req_q.wdata : '0;
  assign mem_wstrb = mem_en ? req_q.wstrb : '0;

  assign if_rsp_valid  = (state_q == RESP) && (gnt_q == G_IF);
  assign ls_rsp_valid  = (state_q == RESP) && (gnt_q == G_LS);
  assign dbg_rsp_valid = (state_q == RESP) && (gnt_q == G_DBG);
  assign rsp_rdata     = rdata_q;
  assign busy          = (state_q != IDLE);

endmodule
